// File: rtl/int_to_float_norm.sv
// Two-stage 32-bit integer to IEEE-754 single-precision converter with valid/ready flow control.
// S1 captures sign, magnitude and leading-zero count; S2 normalises, rounds and packs the result.
module int_to_float_norm #(
  parameter int ROUND_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [5:0]  out_lzc,
  output logic        out_inexact
);

  localparam logic RND = (ROUND_EN != 0);

  function automatic logic [5:0] lzc32(input logic [31:0] v);
    logic [5:0] n;
    logic       found;
    n     = 6'd32;
    found = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 6'(31 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  logic        s1_valid_q, s1_valid_d;
  logic        s1_sign_q, s1_sign_d;
  logic [31:0] s1_mag_q, s1_mag_d;
  logic [5:0]  s1_lzc_q, s1_lzc_d;
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic [5:0]  out_lzc_q, out_lzc_d;
  logic        out_inexact_q, out_inexact_d;

  logic        s2_load;
  logic        s1_load;
  logic        in_sign;
  logic [31:0] in_mag;
  logic [31:0] norm_m;
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [23:0] frac_sum;
  logic [7:0]  exp_w;

  // Ready depends only on register state and out_ready, never on in_valid.
  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  assign in_sign = in_signed & in_data[31];
  assign in_mag  = in_sign ? (~in_data + 32'd1) : in_data;

  assign norm_m   = s1_mag_q << s1_lzc_q;
  assign guard    = norm_m[7];
  assign sticky   = |norm_m[6:0];
  assign round_up = RND & guard & (sticky | norm_m[8]);
  assign frac_sum = {1'b0, norm_m[30:8]} + {23'd0, round_up};
  // 158 + carry never exceeds 8 bits, so no wider exponent is needed.
  assign exp_w    = 8'd158 - {2'b00, s1_lzc_q} + {7'd0, frac_sum[23]};

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_mag_d   = s1_mag_q;
    s1_lzc_d   = s1_lzc_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sign_d = in_sign;
        s1_mag_d  = in_mag;
        s1_lzc_d  = lzc32(in_mag);
      end
    end
  end

  always_comb begin
    s2_valid_d    = s2_valid_q;
    out_data_d    = out_data_q;
    out_lzc_d     = out_lzc_q;
    out_inexact_d = out_inexact_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_lzc_d     = s1_lzc_q;
        out_inexact_d = guard | sticky;
        // A normalised non-zero magnitude always has its MSB set.
        if (!norm_m[31]) out_data_d = 32'd0;
        else             out_data_d = {s1_sign_q, exp_w, frac_sum[22:0]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_sign_q     <= 1'b0;
      s1_mag_q      <= 32'd0;
      s1_lzc_q      <= 6'd0;
      s2_valid_q    <= 1'b0;
      out_data_q    <= 32'd0;
      out_lzc_q     <= 6'd0;
      out_inexact_q <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_sign_q     <= s1_sign_d;
      s1_mag_q      <= s1_mag_d;
      s1_lzc_q      <= s1_lzc_d;
      s2_valid_q    <= s2_valid_d;
      out_data_q    <= out_data_d;
      out_lzc_q     <= out_lzc_d;
      out_inexact_q <= out_inexact_d;
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_data    = out_data_q;
  assign out_lzc     = out_lzc_q;
  assign out_inexact = out_inexact_q;

endmodule

// File: tb/tb_int_to_float_norm.sv
// Directed-vector bench for int_to_float_norm: conversion, rounding modes, latency,
// streaming, backpressure and asynchronous reset behaviour.
module tb_int_to_float_norm;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_signed;
  logic [31:0] in_data;
  logic        out_ready;
  logic        in_ready, out_valid, out_inexact;
  logic [31:0] out_data;
  logic [5:0]  out_lzc;
  logic        in_ready_t, out_valid_t, out_inexact_t;
  logic [31:0] out_data_t;
  logic [5:0]  out_lzc_t;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  int_to_float_norm #(.ROUND_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_signed(in_signed), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_lzc(out_lzc),
    .out_inexact(out_inexact)
  );

  int_to_float_norm #(.ROUND_EN(0)) dut_t (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_t),
    .in_data(in_data), .in_signed(in_signed), .out_valid(out_valid_t),
    .out_ready(out_ready), .out_data(out_data_t), .out_lzc(out_lzc_t),
    .out_inexact(out_inexact_t)
  );

  // Vector table: operand, signedness, rounded result, truncated result, lzc, inexact.
  localparam int NV = 9;
  logic [31:0] v_data [NV] = '{32'h00000001, 32'hFFFFFFFF, 32'h01000001, 32'h01000003,
                               32'hFFFFFFFF, 32'h80000000, 32'h00000000, 32'h00FFFFFF,
                               32'h00000005};
  logic        v_sgn  [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [31:0] v_rne  [NV] = '{32'h3F800000, 32'h4F800000, 32'h4B800000, 32'h4B800002,
                               32'hBF800000, 32'hCF000000, 32'h00000000, 32'h4B7FFFFF,
                               32'h40A00000};
  logic [31:0] v_trn  [NV] = '{32'h3F800000, 32'h4F7FFFFF, 32'h4B800000, 32'h4B800001,
                               32'hBF800000, 32'hCF000000, 32'h00000000, 32'h4B7FFFFF,
                               32'h40A00000};
  logic [5:0]  v_lzc  [NV] = '{6'd31, 6'd0, 6'd7, 6'd7, 6'd31, 6'd0, 6'd32, 6'd8, 6'd29};
  logic        v_inx  [NV] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_data = 32'd0; in_signed = 1'b0; out_ready = 1'b0;
    #12;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 32'd0 || out_lzc !== 6'd0 || out_inexact !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got valid=%b data=%h lzc=%0d inexact=%b, expected all zero",
               out_valid, out_data, out_lzc, out_inexact);
    end
    @(posedge clk); #1 rst = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_convert;
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = v_data[i]; in_signed = v_sgn[i]; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL conv_early[%0d]: out_valid=%b one edge after transfer, expected 0", i, out_valid);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== v_rne[i] || out_lzc !== v_lzc[i] || out_inexact !== v_inx[i]) begin
        n_err++;
        $display("FAIL conv_rne[%0d]: in=%h s=%b got v=%b data=%h lzc=%0d inx=%b expected v=1 data=%h lzc=%0d inx=%b",
                 i, v_data[i], v_sgn[i], out_valid, out_data, out_lzc, out_inexact, v_rne[i], v_lzc[i], v_inx[i]);
      end
      n_cmp++;
      if (out_valid_t !== 1'b1 || out_data_t !== v_trn[i] || out_lzc_t !== v_lzc[i] || out_inexact_t !== v_inx[i]) begin
        n_err++;
        $display("FAIL conv_trunc[%0d]: in=%h s=%b got v=%b data=%h lzc=%0d inx=%b expected v=1 data=%h lzc=%0d inx=%b",
                 i, v_data[i], v_sgn[i], out_valid_t, out_data_t, out_lzc_t, out_inexact_t, v_trn[i], v_lzc[i], v_inx[i]);
      end
      $display("conv %0d: in=%h signed=%b -> %h lzc=%0d inexact=%b (trunc %h)",
               i, v_data[i], v_sgn[i], out_data, out_lzc, out_inexact, out_data_t);
    end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (k >= 2) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== v_rne[k-2]) begin
          n_err++;
          $display("FAIL b2b_out[%0d]: got v=%b data=%h expected v=1 data=%h", k - 2, out_valid, out_data, v_rne[k-2]);
        end
        $display("b2b %0d: out=%h", k - 2, out_data);
      end
      if (k < 4) begin
        n_cmp++;
        if (in_ready !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_ready[%0d]: got %b expected 1", k, in_ready);
        end
        in_valid = 1'b1; in_data = v_data[k]; in_signed = v_sgn[k];
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_backpressure;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h00000001; in_signed = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_ready_one: got %b expected 1", in_ready);
    end
    in_data = 32'hFFFFFFFF; in_signed = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_ready_fall: got %b expected 0", in_ready);
    end
    in_data = 32'h00FFFFFF; in_signed = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h3F800000 || out_lzc !== 6'd31 || out_inexact !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got rdy=%b v=%b data=%h lzc=%0d inx=%b expected rdy=0 v=1 data=3f800000 lzc=31 inx=0",
                 c, in_ready, out_valid, out_data, out_lzc, out_inexact);
      end
      $display("bp hold %0d: out=%h in_ready=%b", c, out_data, in_ready);
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_ready_rise: got %b expected 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 32'hBF800000) begin
      n_err++;
      $display("FAIL bp_drain_b: got v=%b data=%h expected v=1 data=bf800000", out_valid, out_data);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 32'h4B7FFFFF) begin
      n_err++;
      $display("FAIL bp_drain_c: got v=%b data=%h expected v=1 data=4b7fffff", out_valid, out_data);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_no_dup: got out_valid=%b expected 0", out_valid);
    end
    $display("bp drain complete");
  endtask

  task automatic test_reset_midop;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h00000001; in_signed = 1'b0;
    @(posedge clk); #1;
    in_data = 32'h00000005;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 32'd0) begin
      n_err++;
      $display("FAIL midrst_flush: got v=%b data=%h expected v=0 data=00000000", out_valid, out_data);
    end
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h01000003; in_signed = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_early: got out_valid=%b expected 0", out_valid);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 32'h4B800002) begin
      n_err++;
      $display("FAIL midrst_result: got v=%b data=%h expected v=1 data=4b800002", out_valid, out_data);
    end
    $display("post-reset operand: out=%h", out_data);
  endtask

  initial begin
    test_reset;
    test_convert;
    test_back_to_back;
    test_backpressure;
    test_reset_midop;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/int_to_float_norm.md
INT_TO_FLOAT_NORM -- requirements
Module: int_to_float_norm

Interface
REQ-001 The block SHALL have one parameter: ROUND_EN, default 1; 1 = round-to-nearest-even, 0 = truncate toward zero.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: in_data/in_signed are valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block accepts the input this cycle.
REQ-006 The block SHALL have port in_data, input, 32 bits: integer operand.
REQ-007 The block SHALL have port in_signed, input, 1 bit: 1 = two's-complement operand, 0 = unsigned operand.
REQ-008 The block SHALL have port out_valid, output, 1 bit: result valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: consumer takes the result this cycle.
REQ-010 The block SHALL have port out_data, output, 32 bits: IEEE-754 single-precision result.
REQ-011 The block SHALL have port out_lzc, output, 6 bits: leading-zero count of the magnitude, 0..32, with 32 meaning zero.
REQ-012 The block SHALL have port out_inexact, output, 1 bit: result differs from the exact integer value.

Function
REQ-013 A transfer SHALL occur on an edge where valid and ready are both 1; no other edge transfers data.
REQ-014 The pipeline SHALL be two register stages: S1 (sign, magnitude, lzc) and S2 (packed result).
REQ-015 Latency SHALL be exactly 2 cycles from the input-transfer edge to out_valid=1, with no stalls.
REQ-016 Throughput SHALL be one result per cycle while out_ready=1.
REQ-017 S2 SHALL load when S2 is empty or out_ready=1.
REQ-018 S1 SHALL load when S1 is empty or S2 loads.
REQ-019 in_ready SHALL equal the S1 load condition, computed combinationally from register state and out_ready only, never from in_valid.
REQ-020 While out_valid=1 and out_ready=0, out_data, out_lzc and out_inexact SHALL hold stable.
REQ-021 S1 sign SHALL be in_signed & in_data[31]; magnitude SHALL be the two's-complement negation of in_data when sign=1, else in_data (32-bit, unsigned).
REQ-022 S1 lzc SHALL be the number of leading zeros of the magnitude, MSB first, with 32 for zero.
REQ-023 S2 SHALL form m = magnitude << lzc (32 bits), fraction = m[30:8], guard = m[7], sticky = OR of m[6:0].
REQ-024 With ROUND_EN=1, S2 SHALL increment the fraction when guard & (sticky | m[8]).
REQ-025 A fraction carry-out SHALL zero the fraction and increment the exponent.
REQ-026 The exponent SHALL be 158 - lzc, plus any rounding carry; out_data = {sign, exponent[7:0], fraction}.
REQ-027 A zero magnitude SHALL give out_data = 0x00000000, out_lzc = 32, out_inexact = 0, regardless of in_signed.
REQ-028 out_inexact SHALL be guard | sticky, in both rounding modes.
REQ-029 Signed 0x80000000 SHALL give magnitude 0x80000000, lzc 0, out_data 0xCF000000.

Reset
REQ-030 While rst=1, both stage valid flags, out_valid, out_data, out_lzc and out_inexact SHALL be 0, and in_ready SHALL be 1 after release.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight operands immediately, asynchronously, with no output transfer.
REQ-032 The first accepted operand after reset SHALL appear after exactly 2 cycles.

Verification
REQ-033 Unsigned 0x00000001, out_ready=1 -> 2 cycles later: out_data 0x3F800000, out_lzc 31, out_inexact 0.
REQ-034 Unsigned 0xFFFFFFFF -> 0x4F800000, out_lzc 0, out_inexact 1; with ROUND_EN=0 -> 0x4F7FFFFF.
REQ-035 Unsigned 0x01000001 -> 0x4B800000 (tie to even, down), inexact 1; 0x01000003 -> 0x4B800002 (tie, up).
REQ-036 Signed 0xFFFFFFFF -> 0xBF800000; signed 0x80000000 -> 0xCF000000; 0x00000000 -> 0x00000000, out_lzc 32.
REQ-037 Backpressure: stream 3 operands with out_ready=0 -> in_ready falls after 2 accepted; outputs hold; raising out_ready -> results delivered in order, none lost or duplicated.
REQ-038 Reset pulse with both stages full -> out_valid 0 immediately; the next operand emerges 2 cycles after acceptance.
